sprite_overlay: RTL and testbench

//  Pixel-pipeline stage downstream of vgaController: takes raster position/de plus a background RGB and

---
 rtl/sprite_overlay.sv | 204 ++++++++++++++++++++
 tb/tb_sprite_overlay.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_overlay
//  Description : Two-stage pixel pipeline that overlays one animated
//                SPR_W x SPR_H sprite (two images in an internal bitmap RAM)
//                onto a background RGB stream. Sprite moves are requested
//                over a valid/ready port and applied only at frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_overlay #(
    parameter int          SPR_W       = 16,
    parameter int          SPR_H       = 16,
    parameter int          V_RES       = 480,
    parameter int          ANIM_FRAMES = 8,
    parameter logic [11:0] TRANSP      = 12'hF0F,
    parameter logic [9:0]  INIT_X      = 10'd0,
    parameter logic [9:0]  INIT_Y      = 10'd0
) (
    input  logic                                 clk_pix,
    input  logic                                 rst_pix,
    input  logic [9:0]                           hCount,
    input  logic [9:0]                           vCount,
    input  logic                                 de,
    input  logic [7:0]                           bg_r,
    input  logic [7:0]                           bg_g,
    input  logic [7:0]                           bg_b,
    input  logic                                 pos_valid,
    output logic                                 pos_ready,
    input  logic [9:0]                           pos_x,
    input  logic [9:0]                           pos_y,
    input  logic                                 bmp_we,
    input  logic [$clog2(2*SPR_W*SPR_H)-1:0]     bmp_addr,
    input  logic [11:0]                          bmp_data,
    output logic [7:0]                           pix_r,
    output logic [7:0]                           pix_g,
    output logic [7:0]                           pix_b,
    output logic                                 pix_de,
    output logic [9:0]                           pix_sx,
    output logic [9:0]                           pix_sy
);

    localparam int          c_CW        = $clog2(SPR_W);
    localparam int          c_RH        = $clog2(SPR_H);
    localparam int          c_AW        = $clog2(2*SPR_W*SPR_H);
    localparam int          c_DEPTH     = 2*SPR_W*SPR_H;
    localparam int          c_ACW       = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [10:0] c_SPR_W11   = 11'(SPR_W);
    localparam logic [10:0] c_SPR_H11   = 11'(SPR_H);
    localparam logic [9:0]  c_V_RES10   = 10'(V_RES);
    localparam logic [c_ACW-1:0] c_ANIM_LAST = c_ACW'(ANIM_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } pos_state_t;

    pos_state_t       r_state;
    pos_state_t       w_state_nxt;
    logic             w_capture;
    logic             w_apply;
    logic             w_frame_bnd;

    logic [9:0]       r_pend_x, r_pend_y;
    logic [9:0]       r_act_x,  r_act_y;
    logic [c_ACW-1:0] r_anim_cnt;
    logic             r_img;

    logic [10:0]      w_dx, w_dy;
    logic             w_hit;
    logic [c_AW-1:0]  w_rd_addr;

    logic [11:0]      r_mem [0:c_DEPTH-1];
    logic [11:0]      r_texel;

    logic             r_hit1, r_de1;
    logic [23:0]      r_bg1;
    logic [9:0]       r_sx1, r_sy1;
    logic [23:0]      w_rgb;

    // Raw raster position marks the frame boundary regardless of de.
    assign w_frame_bnd = (hCount == 10'd0) && (vCount == c_V_RES10);
    assign pos_ready   = (r_state == ST_EMPTY);

    // Position-request state register.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) r_state <= ST_EMPTY;
        else         r_state <= w_state_nxt;
    end

    // Next-state: one pending slot, drained only at a frame boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (pos_valid) begin
                    w_state_nxt = ST_HELD;
                    w_capture   = 1'b1;
                end
            end
            ST_HELD: begin
                if (w_frame_bnd) begin
                    w_state_nxt = ST_EMPTY;
                    w_apply     = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Pending and active sprite position registers.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_pend_x <= 10'd0;
            r_pend_y <= 10'd0;
            r_act_x  <= INIT_X;
            r_act_y  <= INIT_Y;
        end else begin
            if (w_capture) begin
                r_pend_x <= pos_x;
                r_pend_y <= pos_y;
            end
            if (w_apply) begin
                r_act_x <= r_pend_x;
                r_act_y <= r_pend_y;
            end
        end
    end

    // Animation: count frames, flip the image every ANIM_FRAMES boundaries.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_anim_cnt <= '0;
            r_img      <= 1'b0;
        end else if (w_frame_bnd) begin
            if (r_anim_cnt == c_ANIM_LAST) begin
                r_anim_cnt <= '0;
                r_img      <= ~r_img;
            end else begin
                r_anim_cnt <= r_anim_cnt + 1'b1;
            end
        end
    end

    // Stage 1 hit test: unsigned offsets so off-screen overhang never wraps.
    assign w_dx      = {1'b0, hCount} - {1'b0, r_act_x};
    assign w_dy      = {1'b0, vCount} - {1'b0, r_act_y};
    assign w_hit     = de && (hCount >= r_act_x) && (w_dx < c_SPR_W11) &&
                       (vCount >= r_act_y) && (w_dy < c_SPR_H11);
    assign w_rd_addr = {r_img, w_dy[c_RH-1:0], w_dx[c_CW-1:0]};

    // Bitmap RAM: synchronous read returns the pre-write contents.
    always_ff @(posedge clk_pix) begin
        if (bmp_we) r_mem[bmp_addr] <= bmp_data;
        r_texel <= r_mem[w_rd_addr];
    end

    // Stage 1 registers: carry background, timing and hit alongside the read.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_hit1 <= 1'b0;
            r_de1  <= 1'b0;
            r_bg1  <= 24'd0;
            r_sx1  <= 10'd0;
            r_sy1  <= 10'd0;
        end else begin
            r_hit1 <= w_hit;
            r_de1  <= de;
            r_bg1  <= {bg_r, bg_g, bg_b};
            r_sx1  <= hCount;
            r_sy1  <= vCount;
        end
    end

    // Stage 2 compositing: opaque texel wins, blanking forces black.
    always_comb begin
        w_rgb = r_bg1;
        if (r_hit1 && (r_texel != TRANSP))
            w_rgb = {r_texel[11:8], r_texel[11:8], r_texel[7:4], r_texel[7:4],
                     r_texel[3:0],  r_texel[3:0]};
        if (!r_de1)
            w_rgb = 24'd0;
    end

    // Stage 2 output registers.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            pix_r  <= 8'd0;
            pix_g  <= 8'd0;
            pix_b  <= 8'd0;
            pix_de <= 1'b0;
            pix_sx <= 10'd0;
            pix_sy <= 10'd0;
        end else begin
            {pix_r, pix_g, pix_b} <= w_rgb;
            pix_de <= r_de1;
            pix_sx <= r_sx1;
            pix_sy <= r_sy1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_overlay
//  Description : Self-checking bench for sprite_overlay. A behavioural model
//                (bitmap array, frame count, pending/active position) predicts
//                each output pixel two cycles ahead.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_overlay;

    localparam int          SPR_W  = 16;
    localparam int          SPR_H  = 16;
    localparam int          V_RES  = 480;
    localparam int          AF     = 2;
    localparam logic [11:0] TRANSP = 12'hF0F;

    logic        clk_pix = 1'b0;
    logic        rst_pix;
    logic [9:0]  hCount, vCount;
    logic        de;
    logic [7:0]  bg_r, bg_g, bg_b;
    logic        pos_valid;
    logic        pos_ready;
    logic [9:0]  pos_x, pos_y;
    logic        bmp_we;
    logic [8:0]  bmp_addr;
    logic [11:0] bmp_data;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        pix_de;
    logic [9:0]  pix_sx, pix_sy;

    always #20 clk_pix = ~clk_pix;

    sprite_overlay #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .V_RES(V_RES), .ANIM_FRAMES(AF),
        .TRANSP(TRANSP), .INIT_X(10'd0), .INIT_Y(10'd0)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .hCount(hCount), .vCount(vCount),
        .de(de), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_x(pos_x), .pos_y(pos_y),
        .bmp_we(bmp_we), .bmp_addr(bmp_addr), .bmp_data(bmp_data),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_de(pix_de),
        .pix_sx(pix_sx), .pix_sy(pix_sy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [11:0] m_mem [0:2*SPR_W*SPR_H-1];
    int          m_ax, m_ay, m_px, m_py;
    bit          m_full;
    int          m_bnd;
    logic [44:0] q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int cur_img();
        return (m_bnd / AF) % 2;
    endfunction

    function automatic logic [44:0] model_pix();
        int h, v;
        logic [11:0] tex;
        logic [23:0] rgb;
        h = int'(hCount);
        v = int'(vCount);
        if (!de) return {1'b0, hCount, vCount, 24'h0};
        rgb = {bg_r, bg_g, bg_b};
        if (h >= m_ax && h < m_ax + SPR_W && v >= m_ay && v < m_ay + SPR_H) begin
            tex = m_mem[cur_img()*SPR_W*SPR_H + (v - m_ay)*SPR_W + (h - m_ax)];
            if (tex != TRANSP)
                rgb = {tex[11:8], tex[11:8], tex[7:4], tex[7:4], tex[3:0], tex[3:0]};
        end
        return {1'b1, hCount, vCount, rgb};
    endfunction

    task automatic model_update();
        bit bnd;
        bnd = (hCount == 10'd0) && (int'(vCount) == V_RES);
        if (rst_pix) begin
            m_full = 1'b0;
            m_ax = 0; m_ay = 0;
            m_bnd = 0;
        end else begin
            if (m_full && bnd) begin
                m_ax = m_px; m_ay = m_py; m_full = 1'b0;
            end else if (!m_full && pos_valid) begin
                m_px = int'(pos_x); m_py = int'(pos_y); m_full = 1'b1;
            end
            if (bnd) m_bnd++;
        end
        if (bmp_we) m_mem[bmp_addr] = bmp_data;
    endtask

    // One clock: predict, clock, then compare the pixel issued two cycles ago.
    task automatic tick(input string tag);
        logic [44:0] e;
        e = model_pix();
        if (rst_pix) begin
            e = '0;
            if (q.size() > 0) q[q.size()-1] = '0;
        end
        q.push_back(e);
        @(posedge clk_pix);
        model_update();
        @(negedge clk_pix);
        if (q.size() >= 2) begin
            e = q.pop_front();
            chk(tag, {19'h0, pix_de, pix_sx, pix_sy, pix_r, pix_g, pix_b}, {19'h0, e});
        end
        chk("pos_ready", {63'h0, pos_ready}, {63'h0, !m_full});
        bmp_we    = 1'b0;
        pos_valid = 1'b0;
    endtask

    task automatic set_pix(input int h, input int v, input bit d);
        hCount = 10'(h);
        vCount = 10'(v);
        de     = d;
        bg_r   = 8'($urandom);
        bg_g   = 8'($urandom);
        bg_b   = 8'($urandom);
    endtask

    task automatic boundary();
        set_pix(0, V_RES, 1'b0);
        tick("frame_bnd");
    endtask

    task automatic request(input int x, input int y);
        pos_valid = 1'b1;
        pos_x = 10'(x);
        pos_y = 10'(y);
    endtask

    task automatic scan(input int x0, input int y0, input int w, input int h, input string tag);
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++) begin
                set_pix(x & 1023, y & 1023, $urandom_range(0, 7) != 0);
                tick(tag);
            end
    endtask

    initial begin
        rst_pix = 1'b1; pos_valid = 1'b0; pos_x = '0; pos_y = '0;
        bmp_we = 1'b0; bmp_addr = '0; bmp_data = '0;
        m_full = 1'b0; m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_bnd = 0;
        set_pix(321, 100, 1'b1);
        repeat (3) tick("reset");
        chk("reset_rgb", {40'h0, pix_r, pix_g, pix_b}, 64'h0);
        chk("reset_de",  {63'h0, pix_de}, 64'h0);
        rst_pix = 1'b0;

        // Bitmap load: random texels, some transparent; origin of img0 keyed.
        for (int i = 0; i < 2*SPR_W*SPR_H; i++) begin
            bmp_we   = 1'b1;
            bmp_addr = 9'(i);
            bmp_data = ($urandom_range(0, 7) == 0) ? TRANSP : 12'($urandom);
            if (i == 0) bmp_data = TRANSP;
            if (i == 1) bmp_data = 12'h0F0;
            set_pix(700, 10, 1'b0);
            tick("load");
        end

        // Sprite at (100,50): edges, latency, transparency at origin.
        request(100, 50); set_pix(5, 5, 1'b1); tick("req");
        boundary();
        scan(96, 48, 24, 20, "latency");

        // Handshake: second request while held must be ignored.
        request(200, 300); set_pix(110, 55, 1'b1); tick("hs_req");
        for (int i = 0; i < 4; i++) begin
            request(7, 7); set_pix(100 + i, 50, 1'b1); tick("hs_held");
        end
        scan(96, 48, 24, 4, "hs_unmoved");
        boundary();
        scan(196, 296, 24, 22, "hs_moved");

        // Clipping at the bottom-right corner, no wrap to top-left.
        request(632, 472); set_pix(3, 3, 1'b1); tick("clip_req");
        boundary();
        scan(620, 460, 30, 30, "clip");
        scan(0, 0, 12, 12, "no_wrap");

        // Animation across 8 frames.
        request(100, 50); set_pix(3, 3, 1'b1); tick("anim_req");
        for (int f = 0; f < 8; f++) begin
            boundary();
            scan(100, 50, 16, 16, "anim");
        end

        // Mid-frame reset drops the pending request.
        request(300, 200); set_pix(120, 60, 1'b1); tick("mr_req");
        scan(100, 50, 8, 1, "mr_pre");
        rst_pix = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_pix(101 + i, 51, 1'b1); tick("mr_rst");
        end
        rst_pix = 1'b0;
        boundary();
        scan(0, 0, 20, 20, "post_rst");

        // Randomised mix around the current sprite.
        for (int n = 0; n < 3000; n++) begin
            int r, h, v;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                boundary();
            end else begin
                h = (m_ax + $urandom_range(0, 24) - 4) & 1023;
                v = (m_ay + $urandom_range(0, 24) - 4) & 1023;
                set_pix(h, v, $urandom_range(0, 9) != 0);
                if (r < 8) request($urandom_range(0, 1023), $urandom_range(0, 1023));
                if (r >= 8 && r < 16) begin
                    bmp_we   = 1'b1;
                    bmp_data = ($urandom_range(0, 3) == 0) ? TRANSP : 12'($urandom);
                    bmp_addr = 9'(cur_img()*SPR_W*SPR_H + ((v - m_ay) & (SPR_H-1))*SPR_W
                                  + ((h - m_ax) & (SPR_W-1)));
                end
                rst_pix = (r == 16);
                tick("random");
                rst_pix = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
